// File: rtl/fp_arb_pkg.sv
// ---------------------------------------------------------------------------
// fp_arb_pkg
// Shared definitions for the floating-point adder arbiter slice.
//   - state_e    : arbiter FSM states (IDLE, ISSUE, WAIT, RESPOND)
//   - FP_W       : width of operands/results of the shared adder
//   - ST_W       : width of the adder status word
//   - STATUS_*   : status codes returned to requesters
// ---------------------------------------------------------------------------
package fp_arb_pkg;

    localparam int FP_W = 32;
    localparam int ST_W = 4;

    localparam logic [ST_W-1:0] STATUS_EXACT     = 4'd0;
    localparam logic [ST_W-1:0] STATUS_OVERFLOW  = 4'd1;
    localparam logic [ST_W-1:0] STATUS_UNDERFLOW = 4'd2;
    localparam logic [ST_W-1:0] STATUS_INEXACT   = 4'd3;
    // Not produced by the adder; reported when the adder never answers.
    localparam logic [ST_W-1:0] STATUS_TIMEOUT   = 4'd8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector. Picks the first asserted request at or
// above the priority pointer, wrapping modulo N_REQ.
// Ports:
//   req        in  N_REQ   request vector
//   ptr        in  IDX_W   index of the highest-priority requester
//   grant      out N_REQ   one-hot grant (all zero when no request)
//   grant_idx  out IDX_W   binary index of the granted requester
//   any_req    out 1       at least one request is asserted
// ---------------------------------------------------------------------------
module rr_arbiter
    import fp_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_v;
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        idx_v     = '0;
        // Walk the requesters starting at the pointer; the first hit wins.
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_v = IDX_W'(idx);
            if (!any_req && req[idx_v]) begin
                any_req      = 1'b1;
                grant[idx_v] = 1'b1;
                grant_idx    = idx_v;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// fp_add_arbiter
// Shares one custom-format floating-point adder between N_REQ requesters.
// One operation is in flight at a time; requesters are served round-robin.
// The adder sees stable operands from ISSUE until the response is taken,
// a one-cycle fpu_start, and answers with a one-cycle fpu_done.
//
// Optional build macro: FP_ARB_TIMEOUT_EN
//   When defined, WAIT gives up after TIMEOUT_CYCLES cycles without fpu_done
//   and returns resp_data = 0 with resp_status = STATUS_TIMEOUT.
//
// Ports:
//   clock_100kHz  in   1         system clock
//   reset         in   1         asynchronous, active-low
//   req_valid     in   N_REQ     per-requester operation request
//   req_ready     out  N_REQ     one-hot accept (combinational, IDLE only)
//   req_a/req_b   in   32*N_REQ  operands, requester i at [32i+31:32i]
//   resp_valid    out  N_REQ     one-hot registered result valid
//   resp_ready    in   N_REQ     per-requester result accept
//   resp_data     out  32        result word
//   resp_status   out  4         adder status or timeout code
//   fpu_op_a/b    out  32        operands to the adder
//   fpu_start     out  1         one-cycle start pulse
//   fpu_done      in   1         one-cycle result-valid pulse
//   fpu_data      in   32        adder result
//   fpu_status    in   4         adder status
//   busy          out  1         FSM is not in IDLE
// ---------------------------------------------------------------------------
module fp_add_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock_100kHz,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [FP_W*N_REQ-1:0] req_a,
    input  logic [FP_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]      resp_valid,
    input  logic [N_REQ-1:0]      resp_ready,
    output logic [FP_W-1:0]       resp_data,
    output logic [ST_W-1:0]       resp_status,
    output logic [FP_W-1:0]       fpu_op_a,
    output logic [FP_W-1:0]       fpu_op_b,
    output logic                  fpu_start,
    input  logic                  fpu_done,
    input  logic [FP_W-1:0]       fpu_data,
    input  logic [ST_W-1:0]       fpu_status,
    output logic                  busy
);

    localparam int IDX_W = $clog2(N_REQ);

    // Reject configurations the datapath cannot support.
    if (N_REQ < 2) begin : g_bad_n_req
        $error("fp_add_arbiter: N_REQ must be >= 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("fp_add_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [FP_W-1:0]  op_a_q, op_a_d;
    logic [FP_W-1:0]  op_b_q, op_b_d;
    logic [FP_W-1:0]  resp_data_q, resp_data_d;
    logic [ST_W-1:0]  resp_status_q, resp_status_d;
    logic [N_REQ-1:0] resp_valid_q, resp_valid_d;

`ifdef FP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             any_req;
    logic [FP_W-1:0]  sel_a;
    logic [FP_W-1:0]  sel_b;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*FP_W +: FP_W];
                sel_b = req_b[i*FP_W +: FP_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gidx_d        = gidx_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        resp_data_d   = resp_data_q;
        resp_status_d = resp_status_q;
        resp_valid_d  = resp_valid_q;
`ifdef FP_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // req_ready mirrors the grant here, so any request is a handshake.
                if (any_req) begin
                    gidx_d  = grant_idx;
                    op_a_d  = sel_a;
                    op_b_d  = sel_b;
                    ptr_d   = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef FP_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // fpu_done wins over a timeout landing in the same cycle.
                if (fpu_done) begin
                    resp_data_d          = fpu_data;
                    resp_status_d        = fpu_status;
                    resp_valid_d         = '0;
                    resp_valid_d[gidx_q] = 1'b1;
                    state_d              = RESPOND;
                end
`ifdef FP_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_data_d          = '0;
                    resp_status_d        = STATUS_TIMEOUT;
                    resp_valid_d         = '0;
                    resp_valid_d[gidx_q] = 1'b1;
                    state_d              = RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESPOND: begin
                // Only the granted requester can complete the response.
                if (resp_ready[gidx_q]) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            gidx_q        <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            resp_data_q   <= '0;
            resp_status_q <= '0;
            resp_valid_q  <= '0;
`ifdef FP_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gidx_q        <= gidx_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            resp_data_q   <= resp_data_d;
            resp_status_q <= resp_status_d;
            resp_valid_q  <= resp_valid_d;
`ifdef FP_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    // req_ready is combinational; it is also forced low while reset is held.
    assign req_ready   = (reset && (state_q == IDLE)) ? grant : '0;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_status = resp_status_q;
    assign fpu_op_a    = op_a_q;
    assign fpu_op_b    = op_b_q;
    assign fpu_start   = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
module tb_fp_add_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic [31:0]  resp_data;
    logic [3:0]   resp_status;
    logic [31:0]  fpu_op_a;
    logic [31:0]  fpu_op_b;
    logic         fpu_start;
    logic         fpu_done;
    logic [31:0]  fpu_data;
    logic [3:0]   fpu_status;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_add_arbiter #(
        .N_REQ          (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock_100kHz (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_status  (resp_status),
        .fpu_op_a     (fpu_op_a),
        .fpu_op_b     (fpu_op_b),
        .fpu_start    (fpu_start),
        .fpu_done     (fpu_done),
        .fpu_data     (fpu_data),
        .fpu_status   (fpu_status),
        .busy         (busy)
    );

    // Per-requester operands (fixed for the whole run).
    logic [31:0] op_a_tab [4];
    logic [31:0] op_b_tab [4];

    // Adder model: done pulses model_delay cycles after the start cycle.
    int          model_delay  = 1;
    bit          model_never  = 1'b0;
    logic [31:0] model_data   = '0;
    logic [3:0]  model_status = '0;
    bit          kick         = 1'b0;
    int          mcnt         = 0;

    initial begin
        fpu_done   = 1'b0;
        fpu_data   = '0;
        fpu_status = '0;
    end

    always @(posedge clk) begin
        fpu_done <= 1'b0;
        if (kick) begin
            fpu_done   <= 1'b1;
            fpu_data   <= 32'hDEAD_BEEF;
            fpu_status <= 4'd3;
        end else if (fpu_start && !model_never) begin
            if (model_delay == 1) begin
                fpu_done   <= 1'b1;
                fpu_data   <= model_data;
                fpu_status <= model_status;
            end else begin
                mcnt <= model_delay - 1;
            end
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                fpu_done   <= 1'b1;
                fpu_data   <= model_data;
                fpu_status <= model_status;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One complete transaction; called at a negedge with the DUT in IDLE.
    task automatic run_op(input logic [3:0] mask, input int g, input logic [31:0] d,
                          input logic [3:0] st, input int dly, input int hold, input bit never);
        logic [3:0] oh;
        int         n;
        bit         bad;
        oh           = 4'b0001 << g;
        req_valid    = mask;
        model_delay  = dly;
        model_data   = d;
        model_status = st;
        model_never  = never;
        #1;
        chk("req_ready_grant", req_ready, oh);
        @(negedge clk);
        chk("fpu_start", fpu_start, 1);
        chk("fpu_op_a", fpu_op_a, op_a_tab[g]);
        chk("fpu_op_b", fpu_op_b, op_b_tab[g]);
        chk("busy", busy, 1);
        n   = 0;
        bad = 1'b0;
        while (resp_valid == 4'b0 && n < 200) begin
            @(negedge clk);
            n++;
            if (req_ready != 4'b0 || fpu_start) bad = 1'b1;
        end
        chk("resp_latency", n, dly + 1);
        chk("no_ready_or_start_in_wait", bad, 0);
        chk("resp_valid", resp_valid, oh);
        chk("resp_data", resp_data, d);
        chk("resp_status", resp_status, st);
        if (hold > 0) begin
            resp_ready = ~oh;
            bad = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                if (resp_valid != oh || resp_data != d || resp_status != st ||
                    req_ready != 4'b0 || fpu_op_a != op_a_tab[g]) bad = 1'b1;
            end
            chk("backpressure_hold", bad, 0);
        end
        resp_ready = oh;
        @(negedge clk);
        resp_ready = 4'b0;
        chk("resp_valid_cleared", resp_valid, 0);
        chk("busy_cleared", busy, 0);
    endtask

    typedef struct {
        logic [3:0]  mask;
        int          g;
        logic [31:0] data;
        logic [3:0]  st;
        int          dly;
        int          hold;
    } vec_t;

    vec_t vecs [11];

    initial begin
        bit bad;
        op_a_tab[0] = 32'h3F80_0000; op_b_tab[0] = 32'h4000_0000;
        op_a_tab[1] = 32'h4080_0000; op_b_tab[1] = 32'h4040_0000;
        op_a_tab[2] = 32'h4100_0000; op_b_tab[2] = 32'h3F00_0000;
        op_a_tab[3] = 32'hC080_0000; op_b_tab[3] = 32'h4200_0000;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = op_a_tab[i];
            req_b[i*32 +: 32] = op_b_tab[i];
        end

        // Grant order follows the pointer: 1 (ptr->2), 3 (ptr->0), then
        // 0,1,2,3,0 under full contention, then mixed masks with wrap-around.
        vecs[0]  = '{4'b0010, 1, 32'h40C0_0000, 4'd0, 6, 0};
        vecs[1]  = '{4'b1000, 3, 32'h4210_0000, 4'd3, 2, 0};
        vecs[2]  = '{4'b1111, 0, 32'h4040_0000, 4'd0, 1, 0};
        vecs[3]  = '{4'b1111, 1, 32'h40C0_0000, 4'd1, 3, 10};
        vecs[4]  = '{4'b1111, 2, 32'h4100_0000, 4'd2, 4, 0};
        vecs[5]  = '{4'b1111, 3, 32'h41F0_0000, 4'd3, 2, 0};
        vecs[6]  = '{4'b1111, 0, 32'h4040_0000, 4'd0, 5, 0};
        vecs[7]  = '{4'b0100, 2, 32'h4110_0000, 4'd0, 1, 0};
        vecs[8]  = '{4'b0011, 0, 32'h0000_0001, 4'd2, 2, 0};
        vecs[9]  = '{4'b0101, 2, 32'h7FFF_FFFF, 4'd1, 3, 0};
        vecs[10] = '{4'b1001, 3, 32'h4208_0000, 4'd3, 2, 0};

        reset      = 1'b0;
        req_valid  = 4'b0;
        resp_ready = 4'b0;
        #2;
        chk("reset_outputs", {req_ready, resp_valid, fpu_start, busy}, 0);
        chk("reset_data", {resp_data, resp_status}, 0);
        chk("reset_ops", {fpu_op_a, fpu_op_b}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            run_op(vecs[v].mask, vecs[v].g, vecs[v].data, vecs[v].st,
                   vecs[v].dly, vecs[v].hold, 1'b0);
        end
        req_valid = 4'b0;

        // Spurious fpu_done while idle must not disturb anything.
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        @(negedge clk);
        chk("spurious_done_resp_valid", resp_valid, 0);
        chk("spurious_done_busy", busy, 0);
        chk("spurious_done_data", resp_data, vecs[10].data);
        chk("spurious_done_status", resp_status, vecs[10].st);

        // Reset during WAIT: requester 0 is granted, pointer moves to 1.
        req_valid   = 4'b0001;
        model_delay = 8;
        model_data  = 32'h1234_5678;
        model_never = 1'b0;
        #1;
        chk("pre_reset_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = 4'b0;
        chk("pre_reset_start", fpu_start, 1);
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("midreset_outputs", {req_ready, resp_valid, fpu_start, busy}, 0);
        chk("midreset_data", {resp_data, resp_status}, 0);
        chk("midreset_ops", {fpu_op_a, fpu_op_b}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy || resp_valid != 4'b0 || resp_data != 32'h0) bad = 1'b1;
        end
        chk("late_done_ignored", bad, 0);
        req_valid = 4'b0101;
        #1;
        chk("pointer_reset_to_0", req_ready, 4'b0001);
        req_valid = 4'b0100;
        #1;
        chk("withdrawal_regrant", req_ready, 4'b0100);
        run_op(4'b0100, 2, 32'h4140_0000, 4'd0, 3, 0, 1'b0);
        req_valid = 4'b0;

`ifdef FP_ARB_TIMEOUT_EN
        // No fpu_done: response 8 cycles after entering WAIT.
        run_op(4'b0010, 1, 32'h0, 4'd8, 8, 0, 1'b1);
        req_valid = 4'b0;
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
